hex_entry_pad: RTL and testbench

Operator input block for the FPGA board: it turns five raw push-buttons into a 4-digit hexadecimal value that the operator edits digit by digit, then delivers it with a valid/ready handshake. It is the input-direction counterpart of the seven-segment display path. It sits beside the display multiplexer, which shows `value` and `cursor`, and feeds the CPU debug/injection port through `out_data`. It has its own synchronizers, debouncers and edit state machine, so raw board pins connect directly.

---
 rtl/hex_entry_pad.sv | 173 +++++++++++++++++
 tb/tb_hex_entry_pad.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_pad.sv
// Five-button hex entry pad: synchronize + debounce raw buttons, edit a DIGITS-wide hex buffer,
// deliver it over a valid/ready port. Optional up/down auto-repeat: HEX_ENTRY_AUTOREPEAT_EN.
module hex_entry_pad #(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned DB_CNT       = 1000000,
  parameter int unsigned REPEAT_DELAY = 50000000,
  parameter int unsigned REPEAT_RATE  = 10000000
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_left,
  input  logic                       btn_right,
  input  logic                       btn_enter,
  output logic [4*DIGITS-1:0]        value,
  output logic [$clog2(DIGITS)-1:0]  cursor,
  output logic                       editing,
  output logic                       out_valid,
  output logic [4*DIGITS-1:0]        out_data,
  input  logic                       out_ready
);

  localparam int unsigned CW    = $clog2(DIGITS);
  localparam int unsigned CNT_W = $clog2(DB_CNT + 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DB_CNT);
  localparam logic [CW-1:0]    CUR_LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, EDIT, HOLD} state_t;

  state_t state, state_nx;
  logic [4*DIGITS-1:0] value_nx, out_data_nx;
  logic [CW-1:0]       cursor_nx;
  logic                out_valid_nx;

  // Button order: 0 up, 1 down, 2 left, 3 right, 4 enter
  logic [4:0]       raw, sync1, sync2, db, db_d, pulse;
  logic [CNT_W-1:0] db_cnt [5];

  assign raw = {btn_enter, btn_right, btn_left, btn_down, btn_up};

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      pulse <= '0;
      for (int unsigned i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      pulse <= db & ~db_d;
      for (int unsigned i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic rep_pulse;

`ifdef HEX_ENTRY_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_phase;
  logic          rep_hold;

  assign rep_hold = (state == EDIT) && (db[0] || db[1]);

  // First repeat after REPEAT_DELAY, then every REPEAT_RATE while held
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      rep_pulse <= 1'b0;
    end else begin
      rep_pulse <= 1'b0;
      if (!rep_hold) begin
        rep_cnt   <= '0;
        rep_phase <= 1'b0;
      end else if (rep_cnt == (rep_phase ? RATE_LAST : DELAY_LAST)) begin
        rep_pulse <= 1'b1;
        rep_cnt   <= '0;
        rep_phase <= 1'b1;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end
`else
  // Repeat timing parameters remain on the interface but have no effect here
  assign rep_pulse = 1'b0 && (REPEAT_DELAY > 0) && (REPEAT_RATE > 0);
`endif

  logic ev_up, ev_down, ev_left, ev_right, ev_enter;
  assign ev_up    = pulse[0] | (rep_pulse & db[0]);
  assign ev_down  = pulse[1] | (rep_pulse & db[1]);
  assign ev_left  = pulse[2];
  assign ev_right = pulse[3];
  assign ev_enter = pulse[4];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      value     <= '0;
      cursor    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      value     <= value_nx;
      cursor    <= cursor_nx;
      out_data  <= out_data_nx;
      out_valid <= out_valid_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    value_nx     = value;
    cursor_nx    = cursor;
    out_data_nx  = out_data;
    out_valid_nx = out_valid;
    unique case (state)
      IDLE: begin
        if (ev_enter) begin
          out_data_nx  = value;
          out_valid_nx = 1'b1;
          state_nx     = HOLD;
        end else if (ev_up || ev_down || ev_left || ev_right) begin
          state_nx = EDIT;
        end
      end
      EDIT: begin
        if (ev_enter) begin
          out_data_nx  = value;
          out_valid_nx = 1'b1;
          state_nx     = HOLD;
        end else if (ev_up) begin
          value_nx[{cursor, 2'b00} +: 4] = value[{cursor, 2'b00} +: 4] + 4'd1;
        end else if (ev_down) begin
          value_nx[{cursor, 2'b00} +: 4] = value[{cursor, 2'b00} +: 4] - 4'd1;
        end else if (ev_left) begin
          cursor_nx = (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
        end else if (ev_right) begin
          cursor_nx = (cursor == '0) ? CUR_LAST : cursor - 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign editing = (state == EDIT);

endmodule

// File: tb/tb_hex_entry_pad.sv
// Bench for hex_entry_pad: directed button presses; committed words checked by a transfer monitor.
module tb_hex_entry_pad;

  localparam int unsigned UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, ENTER = 4;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic [4:0]  btns = '0;
  logic        out_ready = 1'b0;
  logic [15:0] value, out_data;
  logic [1:0]  cursor;
  logic        editing, out_valid;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  logic [15:0] exp_q [$];
  logic [3:0]  seen [$];

  always #5 clk = ~clk;

  hex_entry_pad #(
    .DIGITS(4), .DB_CNT(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)
  ) dut (
    .clk(clk), .Reset(Reset),
    .btn_up(btns[UP]), .btn_down(btns[DOWN]), .btn_left(btns[LEFT]),
    .btn_right(btns[RIGHT]), .btn_enter(btns[ENTER]),
    .value(value), .cursor(cursor), .editing(editing),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int unsigned b);
    btns[b] = 1'b1;
    cyc(12);
    btns[b] = 1'b0;
    cyc(12);
  endtask

  // Transfer monitor: every accepted word must match the oldest expected commit
  always @(negedge clk) begin
    if (Reset && out_valid) begin
      valid_cycles++;
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got 0x%0h with no commit expected", out_data);
        end else begin
          check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] last;
    cyc(5);
    Reset = 1'b1;
    cyc(50);
    check("reset_value", value, 0);
    check("reset_cursor", cursor, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_editing", editing, 0);

    press(UP);
    check("enter_edit", editing, 1);
    check("first_press_no_change", value, 0);
    repeat (3) press(UP);
    press(LEFT);
    press(DOWN);
    check("edit_value", value, 16'h00F3);
    check("edit_cursor", cursor, 1);

    btns[UP] = 1'b1;
    cyc(3);
    btns[UP] = 1'b0;
    cyc(15);
    check("glitch_ignored", value, 16'h00F3);

    repeat (5) press(DOWN);
    press(RIGHT);
    repeat (2) press(UP);
    check("wrap_right_cursor", cursor, 0);
    check("value_a5", value, 16'h00A5);

    out_ready = 1'b0;
    exp_q.push_back(16'h00A5);
    press(ENTER);
    check("hold_valid", out_valid, 1);
    check("hold_data", out_data, 16'h00A5);
    press(UP);
    check("hold_ignores_up", value, 16'h00A5);
    check("hold_valid_after_up", out_valid, 1);
    check("hold_data_after_up", out_data, 16'h00A5);
    cyc(10);
    out_ready = 1'b1;
    cyc(1);
    check("valid_drops", out_valid, 0);
    check("not_editing_after_xfer", editing, 0);

    press(UP);
    check("idle_first_press_value", value, 16'h00A5);
    check("idle_first_press_edit", editing, 1);

    valid_cycles = 0;
    exp_q.push_back(16'h00A5);
    btns[UP] = 1'b1;
    btns[ENTER] = 1'b1;
    cyc(12);
    btns = '0;
    cyc(12);
    check("simul_no_increment", value, 16'h00A5);
    check("simul_valid_one_cycle", valid_cycles, 1);
    check("simul_idle", editing, 0);
    check("queue_drained", exp_q.size(), 0);

    out_ready = 1'b0;
    press(UP);
    press(RIGHT);
    check("cursor_wrap_to_3", cursor, 3);
    press(ENTER);
    check("hold_before_reset", out_valid, 1);
    Reset = 1'b0;
    btns[UP] = 1'b1;
    cyc(2);
    check("rst_value", value, 0);
    check("rst_cursor", cursor, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_editing", editing, 0);
    Reset = 1'b1;
    cyc(12);
    check("held_through_reset_pulse", editing, 1);
    check("held_through_reset_value", value, 0);
    btns[UP] = 1'b0;
    cyc(12);

    out_ready = 1'b1;
    last = 4'h0;
    btns[DOWN] = 1'b1;
    cyc(6);
    for (int i = 0; i < 46; i++) begin
      cyc(1);
      if (i == 40) btns[DOWN] = 1'b0;
      if (value[3:0] != last) begin
        seen.push_back(value[3:0]);
        last = value[3:0];
      end
    end
    cyc(12);
`ifdef HEX_ENTRY_AUTOREPEAT_EN
    check("repeat_count_min", (seen.size() >= 5) ? 1 : 0, 1);
    if (seen.size() >= 5) begin
      check("repeat_0", seen[0], 4'hF);
      check("repeat_1", seen[1], 4'hE);
      check("repeat_2", seen[2], 4'hD);
      check("repeat_3", seen[3], 4'hC);
      check("repeat_4", seen[4], 4'hB);
    end
`else
    check("no_repeat_count", seen.size(), 1);
    check("no_repeat_value", value, 16'h000F);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
